// File: rtl/spike_timestep_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : spike_timestep_scheduler_if
// Brief    : Spike-FIFO read port and PE-array handshake bundle of the
//            timestep scheduler.
// Revision : 1.0
// ============================================================================
interface spike_timestep_scheduler_if #(
    parameter int N_PE     = 4,
    parameter int NEURON_W = 8
);
    logic [15:0]         fifo_dout;
    logic                fifo_empty;
    logic                fifo_rd_en;
    logic [N_PE-1:0]     pe_spike_valid;
    logic [NEURON_W-1:0] pe_spike_index;
    logic [N_PE-1:0]     pe_spike_ready;
    logic                pe_ts_start;
    logic [N_PE-1:0]     pe_ts_done;

    // Scheduler side
    modport master (
        input  fifo_dout, fifo_empty, pe_spike_ready, pe_ts_done,
        output fifo_rd_en, pe_spike_valid, pe_spike_index, pe_ts_start
    );

    // FIFO / PE-array side
    modport slave (
        output fifo_dout, fifo_empty, pe_spike_ready, pe_ts_done,
        input  fifo_rd_en, pe_spike_valid, pe_spike_index, pe_ts_start
    );
endinterface
`default_nettype wire

// File: rtl/spike_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spike_timestep_scheduler
// Brief    : Drains F1FA..FAF1 spike frames from the spike FIFO, routes each
//            spike to its owning PE, then runs one PE timestep per frame.
// Revision : 1.0
// ============================================================================
module spike_timestep_scheduler #(
    parameter int N_PE     = 4,
    parameter int NEURON_W = 8,
    parameter int TS_W     = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        sched_en,
    spike_timestep_scheduler_if.master  bus,
    output logic [TS_W-1:0]             timestep_cnt,
    output logic [15:0]                 frame_spike_cnt,
    output logic                        busy,
    output logic                        err_range,
    output logic                        err_sync
);
    localparam int SEL_W  = $clog2(N_PE);
    localparam int HI_LSB = NEURON_W + SEL_W;

    localparam logic [15:0]     c_sof      = 16'hF1FA;
    localparam logic [15:0]     c_eof      = 16'hFAF1;
    localparam logic [15:0]     c_cnt_max  = 16'hFFFF;
    localparam logic [N_PE-1:0] c_one      = {{(N_PE-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_CHECK    = 3'd2,
        S_DISPATCH = 3'd3,
        S_FIRE     = 3'd4,
        S_WAIT     = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_in_frame;
    logic [N_PE-1:0]     r_done_mask;
    logic [N_PE-1:0]     r_spike_valid;
    logic [NEURON_W-1:0] r_spike_index;
    logic                r_ts_start;
    logic [TS_W-1:0]     r_timestep;
    logic [15:0]         r_frame_cnt;
    logic                r_err_range;
    logic                r_err_sync;

    logic [SEL_W-1:0]    w_sel;
    logic                w_hi_nz;
    logic                w_sel_oob;
    logic                w_drop;
    logic                w_accept;
    logic                w_done_all;

    assign w_sel = bus.fifo_dout[NEURON_W +: SEL_W];

    // The high field vanishes when the PE select reaches bit 15.
    generate
        if (HI_LSB < 16) begin : g_hi_field
            assign w_hi_nz = |bus.fifo_dout[15:HI_LSB];
        end else begin : g_hi_none
            assign w_hi_nz = 1'b0;
        end
    endgenerate

    assign w_sel_oob  = (int'(w_sel) >= N_PE);
    assign w_drop     = w_hi_nz | w_sel_oob;
    assign w_accept   = |(r_spike_valid & bus.pe_spike_ready);
    assign w_done_all = &(r_done_mask | bus.pe_ts_done);

    assign bus.fifo_rd_en     = (r_state == S_FETCH) && !bus.fifo_empty;
    assign bus.pe_spike_valid = r_spike_valid;
    assign bus.pe_spike_index = r_spike_index;
    assign bus.pe_ts_start    = r_ts_start;
    assign timestep_cnt       = r_timestep;
    assign frame_spike_cnt    = r_frame_cnt;
    assign err_range          = r_err_range;
    assign err_sync           = r_err_sync;
    assign busy               = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_in_frame    <= 1'b0;
            r_done_mask   <= '0;
            r_spike_valid <= '0;
            r_spike_index <= '0;
            r_ts_start    <= 1'b0;
            r_timestep    <= '0;
            r_frame_cnt   <= '0;
            r_err_range   <= 1'b0;
            r_err_sync    <= 1'b0;
        end else begin
            r_ts_start  <= 1'b0;
            r_err_range <= 1'b0;
            r_err_sync  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sched_en) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!bus.fifo_empty) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_state <= S_FETCH;
                    if (!r_in_frame) begin
                        // Words outside a frame are dropped without a flag.
                        if (bus.fifo_dout == c_sof) begin
                            r_in_frame  <= 1'b1;
                            r_frame_cnt <= '0;
                        end
                    end else if (bus.fifo_dout == c_eof) begin
                        r_ts_start <= 1'b1;
                        r_state    <= S_FIRE;
                    end else if (bus.fifo_dout == c_sof) begin
                        r_err_sync  <= 1'b1;
                        r_frame_cnt <= '0;
                    end else if (w_drop) begin
                        r_err_range <= 1'b1;
                    end else begin
                        r_spike_index <= bus.fifo_dout[NEURON_W-1:0];
                        r_spike_valid <= c_one << w_sel;
                        r_state       <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (w_accept) begin
                        r_spike_valid <= '0;
                        if (r_frame_cnt != c_cnt_max) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                        r_state <= S_FETCH;
                    end
                end
                S_FIRE: begin
                    // Done seen while start is still high is deliberately ignored.
                    r_done_mask <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_done_mask <= r_done_mask | bus.pe_ts_done;
                    if (w_done_all) begin
                        r_timestep <= r_timestep + 1'b1;
                        r_in_frame <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spike_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_timestep_scheduler
// Brief    : Self-checking bench: frame-level event model plus directed cases.
// Revision : 1.0
// ============================================================================
module tb_spike_timestep_scheduler;
    localparam int N_PE     = 4;
    localparam int NEURON_W = 8;
    localparam int TS_W     = 16;

    localparam int K_DISP = 0;
    localparam int K_ERRR = 1;
    localparam int K_ERRS = 2;
    localparam int K_FIRE = 3;

    typedef struct {
        int kind;
        int pe;
        int idx;
        int cnt;
        int seq;
    } ev_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            sched_en;
    logic [TS_W-1:0] timestep_cnt;
    logic [15:0]     frame_spike_cnt;
    logic            busy;
    logic            err_range;
    logic            err_sync;

    spike_timestep_scheduler_if #(.N_PE(N_PE), .NEURON_W(NEURON_W)) bus ();

    spike_timestep_scheduler #(.N_PE(N_PE), .NEURON_W(NEURON_W), .TS_W(TS_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .sched_en        (sched_en),
        .bus             (bus),
        .timestep_cnt    (timestep_cnt),
        .frame_spike_cnt (frame_spike_cnt),
        .busy            (busy),
        .err_range       (err_range),
        .err_sync        (err_sync)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [15:0] fifo_q[$];
    ev_t         exp_q[$];
    bit          m_in = 1'b0;
    int          m_cnt = 0;
    int          push_seq = 0;
    logic [TS_W-1:0] exp_ts = '0;

    // Environment controls
    bit          chk_en = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          sched_rand = 1'b0;
    bit          use_fixed = 1'b0;
    logic [N_PE-1:0] rdy_hold = '0;
    int          dly_fixed[N_PE] = '{3, 7, 1, 20};

    // Observation state
    bit          rd_seen = 1'b0;
    int          n_starts = 0;
    int          cyc = 0;
    int          rd_count = 0;
    int          read_cyc[int];
    int          start_cyc = 0;
    int          ts_delta = 0;
    int          run_len = 0;
    int          last_run = 0;
    int          n_errr = 0;
    int          n_errs = 0;
    logic [9:0]  disp_log[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N_PE-1:0] v);
        for (int i = 0; i < N_PE; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Frame-level model: the expected event stream follows from word order alone.
    task automatic push_word(input logic [15:0] w);
        ev_t e;
        int  gid;
        int  pe;
        fifo_q.push_back(w);
        gid   = int'(w);
        pe    = gid / (1 << NEURON_W);
        e.kind = K_DISP; e.pe = 0; e.idx = 0; e.cnt = 0; e.seq = push_seq;
        if (!m_in) begin
            if (w == 16'hF1FA) begin
                m_in  = 1'b1;
                m_cnt = 0;
            end
        end else if (w == 16'hFAF1) begin
            e.kind = K_FIRE; e.cnt = m_cnt;
            exp_q.push_back(e);
            m_in = 1'b0;
        end else if (w == 16'hF1FA) begin
            e.kind = K_ERRS;
            exp_q.push_back(e);
            m_cnt = 0;
        end else if (pe >= N_PE) begin
            e.kind = K_ERRR;
            exp_q.push_back(e);
        end else begin
            e.kind = K_DISP; e.pe = pe; e.idx = gid % (1 << NEURON_W); e.cnt = m_cnt;
            exp_q.push_back(e);
            if (m_cnt < 65535) m_cnt++;
        end
        push_seq++;
    endtask

    task automatic push_gap(input logic [15:0] w);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push_word(w);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    // FIFO, PE-array and sched_en driver
    initial begin
        int cd[N_PE];
        int dl[N_PE];
        int starts_seen = 0;
        logic [N_PE-1:0] d;
        for (int i = 0; i < N_PE; i++) begin cd[i] = 0; dl[i] = 0; end
        bus.fifo_dout      = '0;
        bus.fifo_empty     = 1'b1;
        bus.pe_spike_ready = '1;
        bus.pe_ts_done     = '0;
        sched_en           = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen) begin
                if (fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
                else chk("fifo_underflow", 1, 0);
            end
            bus.fifo_empty = (fifo_q.size() == 0);
            if (n_starts != starts_seen) begin
                starts_seen = n_starts;
                for (int i = 0; i < N_PE; i++) begin
                    cd[i] = use_fixed ? dly_fixed[i] : $urandom_range(1, 20);
                    dl[i] = 0;
                end
            end
            for (int i = 0; i < N_PE; i++) begin
                if (cd[i] > 0) begin
                    cd[i]--;
                    if (cd[i] == 0) dl[i] = use_fixed ? 1 : $urandom_range(1, 3);
                end
                d[i] = (dl[i] > 0);
                if (dl[i] > 0) dl[i]--;
            end
            bus.pe_ts_done     = d;
            bus.pe_spike_ready = (rdy_rand ? 4'($urandom) : 4'hF) & ~rdy_hold;
            sched_en           = sched_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Compare process
    initial begin
        logic [N_PE-1:0]     v;
        logic [N_PE-1:0]     pv = '0;
        logic [NEURON_W-1:0] pidx = '0;
        logic [N_PE-1:0]     mask = '0;
        logic [TS_W-1:0]     prev_ts = '0;
        bit                  prev_stall = 1'b0;
        bit                  prev_start = 1'b0;
        bit                  waiting = 1'b0;
        ev_t                 e;
        forever begin
            @(negedge clk);
            rd_seen = bus.fifo_rd_en;
            if (!chk_en) continue;
            cyc++;
            v = bus.pe_spike_valid;
            chk("valid_onehot", $onehot0(v), 1);
            if (bus.fifo_rd_en) begin
                chk("valid_while_reading", v, 0);
                chk("busy_while_reading", busy, 1);
                read_cyc[rd_count] = cyc;
                rd_count++;
            end
            if (prev_stall) begin
                chk("stall_valid_stable", v, pv);
                chk("stall_index_stable", bus.pe_spike_index, pidx);
            end
            if (v != 0) run_len++;
            if (v != 0 && (v & bus.pe_spike_ready) != 0) begin
                disp_log.push_back({2'(oh_idx(v)), bus.pe_spike_index});
                last_run = run_len; run_len = 0; prev_stall = 1'b0;
                if (exp_q.size() == 0) chk("unexpected_dispatch", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("dispatch_kind", e.kind, K_DISP);
                    chk("dispatch_pe", oh_idx(v), e.pe);
                    chk("dispatch_idx", bus.pe_spike_index, e.idx);
                    chk("dispatch_frame_cnt", frame_spike_cnt, e.cnt);
                end
            end else begin
                prev_stall = (v != 0);
            end
            pv = v; pidx = bus.pe_spike_index;
            if (err_range) begin
                n_errr++;
                if (exp_q.size() == 0) chk("unexpected_err_range", 1, 0);
                else begin e = exp_q.pop_front(); chk("err_range_kind", e.kind, K_ERRR); end
            end
            if (err_sync) begin
                n_errs++;
                chk("err_sync_cnt_cleared", frame_spike_cnt, 0);
                if (exp_q.size() == 0) chk("unexpected_err_sync", 1, 0);
                else begin e = exp_q.pop_front(); chk("err_sync_kind", e.kind, K_ERRS); end
            end
            if (bus.pe_ts_start) begin
                chk("ts_start_one_cycle", prev_start, 0);
                if (exp_q.size() == 0) chk("unexpected_ts_start", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("ts_start_kind", e.kind, K_FIRE);
                    chk("fire_frame_cnt", frame_spike_cnt, e.cnt);
                    chk("fire_latency", cyc - read_cyc[e.seq], 2);
                end
                n_starts++;
                start_cyc = cyc;
                waiting = 1'b1;
                mask = '0;
            end
            prev_start = bus.pe_ts_start;
            chk("timestep_cnt", timestep_cnt, exp_ts);
            if (timestep_cnt != prev_ts) ts_delta = cyc - start_cyc;
            prev_ts = timestep_cnt;
            if (waiting && !bus.pe_ts_start) begin
                mask = mask | bus.pe_ts_done;
                if (&mask) begin
                    waiting = 1'b0;
                    exp_ts  = exp_ts + 1'b1;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        int e0;
        int s0;
        logic [15:0] w;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_valid", bus.pe_spike_valid, 0);
        chk("rst_index", bus.pe_spike_index, 0);
        chk("rst_ts_start", bus.pe_ts_start, 0);
        chk("rst_timestep", timestep_cnt, 0);
        chk("rst_frame_cnt", frame_spike_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_range, err_sync}, 0);
        rstn = 1'b1;
        chk_en = 1'b1;

        // Basic frame with staggered PE done
        @(negedge clk);
        use_fixed = 1'b1;
        push_word(16'hF1FA); push_word(16'h0005); push_word(16'h0103); push_word(16'hFAF1);
        chk("model_event_count", exp_q.size(), 3);
        chk("model_fire_cnt", exp_q[2].cnt, 2);
        wait_idle("drain_basic", 500);
        use_fixed = 1'b0;
        chk("basic_timestep", timestep_cnt, 1);
        chk("basic_frame_cnt", frame_spike_cnt, 2);
        chk("basic_ts_after_last_done", ts_delta, 21);
        chk("basic_disp0", disp_log[0], {2'd0, 8'h05});
        chk("basic_disp1", disp_log[1], {2'd1, 8'h03});

        // Garbage before frame, out-of-range spikes, top PE
        e0 = n_errr; s0 = n_errs;
        push_word(16'h1234); push_word(16'hABCD); push_word(16'hF1FA);
        push_word(16'h0405); push_word(16'h0A00); push_word(16'h03FF); push_word(16'hFAF1);
        wait_idle("drain_range", 500);
        chk("range_err_pulses", n_errr - e0, 2);
        chk("range_no_sync", n_errs - s0, 0);
        chk("range_disp_count", disp_log.size(), 3);
        chk("range_disp_pe3", disp_log[disp_log.size()-1], {2'd3, 8'hFF});

        // Backpressure on PE2 for 10 cycles
        rdy_hold = 4'b0100;
        push_word(16'hF1FA); push_word(16'h0207); push_word(16'hFAF1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.pe_spike_valid[2] && n < 200);
        chk("stall_valid_seen", bus.pe_spike_valid[2], 1);
        repeat (9) @(negedge clk);
        chk("stall_still_valid", bus.pe_spike_valid, 4'b0100);
        rdy_hold = '0;
        wait_idle("drain_stall", 500);
        chk("stall_run_len", last_run, 11);

        // Resync inside a frame, with an empty-FIFO stall mid-frame
        s0 = n_errs;
        push_word(16'hF1FA); push_word(16'h0001);
        repeat (30) @(negedge clk);
        chk("empty_stall_busy", busy, 1);
        chk("empty_stall_valid", bus.pe_spike_valid, 0);
        chk("empty_stall_rd", bus.fifo_rd_en, 0);
        push_word(16'hF1FA); push_word(16'h0002); push_word(16'hFAF1);
        wait_idle("drain_sync", 500);
        chk("sync_err_pulses", n_errs - s0, 1);
        chk("sync_frame_cnt", frame_spike_cnt, 1);

        // Randomized frames
        rdy_rand = 1'b1;
        sched_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 2)) begin
                w = 16'($urandom);
                if (w == 16'hF1FA) w = 16'h0000;
                push_gap(w);
            end
            push_gap(16'hF1FA);
            repeat ($urandom_range(0, 6)) begin
                n = $urandom_range(0, 99);
                if (n < 70) w = {6'd0, 2'($urandom_range(0, 3)), 8'($urandom)};
                else if (n < 88) begin
                    w = 16'($urandom_range(16'h0400, 16'hFFFF));
                    if (w == 16'hF1FA || w == 16'hFAF1) w = 16'h0400;
                end else w = 16'hF1FA;
                push_gap(w);
            end
            push_gap(16'hFAF1);
        end
        sched_rand = 1'b0;
        wait_idle("drain_random", 20000);
        rdy_rand = 1'b0;

        // Asynchronous reset while a spike is being held
        rdy_hold = 4'b0010;
        push_word(16'hF1FA); push_word(16'h0102);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.pe_spike_valid[1] && n < 200);
        chk("rstmid_valid_seen", bus.pe_spike_valid[1], 1);
        chk_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("rstmid_valid", bus.pe_spike_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rd_en", bus.fifo_rd_en, 0);
        chk("rstmid_timestep", timestep_cnt, 0);
        chk("rstmid_frame_cnt", frame_spike_cnt, 0);
        chk("rstmid_ts_start", bus.pe_ts_start, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
